mips_multicycle_control: RTL
============================

# mips_multicycle_control

Main control FSM for the multicycle MIPS datapath. Decodes the 6-bit opcode, sequences fetch/decode/execute/memory/writeback over multiple cycles, and drives all datapath enables and muxes. It produces the 2-bit `ALU_Op` consumed directly by `MIPS_ALU_Decoder`: 00 = add, 01 = subtract, 10 = R-type (use funct). It also runs a request/ready handshake with the unified instruction/data memory.

## Interface
Parameters: none (encodings fixed).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `Opcode` in 6: instruction register bits [31:26].
- `Zero` in 1: ALU zero flag.
- `Mem_Ready` in 1: memory completes the current access this cycle.
- `Mem_Req` out 1: memory access requested.
- `Mem_Write` out 1: requested access is a write.
- `I_or_D` out 1: address select, 0 = PC, 1 = ALUOut.
- `IR_Write` out 1: load instruction register.
- `PC_En` out 1: PC load enable, `PC_Write | (Branch & Zero)`.
- `Reg_Dst` out 1: 0 = rt, 1 = rd.
- `Mem_to_Reg` out 1: 0 = ALUOut, 1 = MDR.
- `Reg_Write` out 1: register file write.
- `ALU_Src_A` out 1: 0 = PC, 1 = A.
- `ALU_Src_B` out 2: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `ALU_Op` out 2: to `MIPS_ALU_Decoder`.
- `PC_Src` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `State` out 4: current state, for debug and verification.

## Operation
- Supported opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010. Any other opcode returns from DECODE to FETCH with no writes.
- States and encodings:
  - FETCH = 0: `Mem_Req` = 1, `ALU_Src_B` = 01. `IR_Write` and `PC_Write` are asserted only while `Mem_Ready` = 1. Stay in FETCH until `Mem_Ready`, then go to DECODE.
  - DECODE = 1: `ALU_Src_B` = 11, `ALU_Op` = 00 (precomputes the branch target).
    - LW or SW → MEMADR
    - R-type → EXEC
    - BEQ → BRANCH
    - ADDI → ADDIEX
    - J → JUMP
    - any other opcode → FETCH
  - MEMADR = 2: `ALU_Src_A` = 1, `ALU_Src_B` = 10. LW → MEMRD, SW → MEMWR.
  - MEMRD = 3: `Mem_Req` = 1, `I_or_D` = 1. Hold until `Mem_Ready`, then go to MEMWB.
  - MEMWB = 4: `Reg_Write` = 1, `Mem_to_Reg` = 1, `Reg_Dst` = 0. Next state FETCH.
  - MEMWR = 5: `Mem_Req` = 1, `Mem_Write` = 1, `I_or_D` = 1. Hold until `Mem_Ready`, then go to FETCH.
  - EXEC = 6: `ALU_Src_A` = 1, `ALU_Src_B` = 00, `ALU_Op` = 10. Next state ALUWB.
  - ALUWB = 7: `Reg_Write` = 1, `Reg_Dst` = 1, `Mem_to_Reg` = 0. Next state FETCH.
  - BRANCH = 8: `ALU_Src_A` = 1, `ALU_Src_B` = 00, `ALU_Op` = 01, `PC_Src` = 01, Branch = 1. Next state FETCH.
  - ADDIEX = 9: `ALU_Src_A` = 1, `ALU_Src_B` = 10, `ALU_Op` = 00. Next state ADDIWB.
  - ADDIWB = 10: `Reg_Write` = 1, `Reg_Dst` = 0, `Mem_to_Reg` = 0. Next state FETCH.
  - JUMP = 11: `PC_Src` = 10, `PC_Write` = 1. Next state FETCH.
  - Encodings 12-15 are illegal and go to FETCH on the next edge.
- Any output not listed for a state is 0.
- Handshake rules:
  - `Mem_Req` and `Mem_Write` stay stable while waiting for `Mem_Ready`.
  - `Mem_Ready` is ignored outside FETCH, MEMRD and MEMWR.

## Timing
- Moore outputs decode from the registered state. The exceptions are FETCH `IR_Write`/`PC_Write`, which are qualified combinationally by `Mem_Ready`, and `PC_En`, which depends on `Zero`.
- Reset: `rst` high forces State = FETCH immediately, without waiting for a clock edge.
  - While `rst` = 1, `IR_Write`, `PC_En`, `Reg_Write`, `Mem_Req` and `Mem_Write` are 0.
  - All other outputs take their FETCH values: `ALU_Src_B` = 01, everything else 0.
  - Reset asserted mid-instruction abandons it; no write enable pulses.
- Cycle counts with zero wait states (`Mem_Ready` tied high):
  - LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.
  - Unsupported opcode: 2 cycles.
- Each cycle of `Mem_Ready` = 0 in FETCH, MEMRD or MEMWR adds one cycle.
- `Opcode` is sampled only in DECODE and MEMADR; it must be stable there because IR is written only in FETCH.

## Test plan
- Reset mid-op:
  - Stimulus: assert `rst` in EXEC, asynchronously between clock edges.
  - Required: State = 0 before the next edge, `Reg_Write` never pulses. After release with `Mem_Ready` = 1, FETCH asserts `IR_Write` = 1 and `PC_En` = 1.
- R-type, zero wait:
  - Stimulus: Opcode = 000000.
  - Required: State sequence 0,1,6,7,0. `ALU_Op` = 10 in EXEC. `Reg_Write` = 1 and `Reg_Dst` = 1 only in ALUWB.
- LW with stalls:
  - Stimulus: Opcode = 100011, `Mem_Ready` low for 2 cycles in FETCH and 3 cycles in MEMRD.
  - Required: total 10 cycles. `Mem_Req` held high throughout each wait. `I_or_D` = 1 in MEMRD. `Mem_to_Reg` = 1 in MEMWB.
- SW:
  - Stimulus: Opcode = 101011, `Mem_Ready` = 1.
  - Required: State sequence 0,1,2,5,0. `Mem_Write` = 1 for exactly one cycle; no `Reg_Write`.
- BEQ:
  - Stimulus: Opcode = 000100, once with `Zero` = 1 and once with `Zero` = 0.
  - Required: in BRANCH, `ALU_Op` = 01, `PC_Src` = 01, and `PC_En` = 1 (Zero = 1) or 0 (Zero = 0).
- J and illegal opcode:
  - Stimulus: Opcode = 000010, then Opcode = 111111.
  - Required: J gives states 0,1,11 with `PC_Src` = 10 and `PC_En` = 1. Illegal gives 0,1,0 with no write enables in DECODE.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Memory handshake between the multicycle control FSM and the unified instruction/data memory.
// The controller (master) requests and the memory (slave) answers with Mem_Ready.
interface mips_multicycle_control_if;
    logic Mem_Req;
    logic Mem_Write;
    logic Mem_Ready;

    modport master (output Mem_Req, output Mem_Write, input Mem_Ready);
    modport slave  (input Mem_Req, input Mem_Write, output Mem_Ready);
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: opcode decode, cycle sequencing,
// datapath enables/mux selects and the memory request/ready handshake.
//
// state   | enc | meaning
// FETCH   | 0   | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE  | 1   | read registers, precompute branch target into ALUOut
// MEMADR  | 2   | compute load/store address A + SignImm
// MEMRD   | 3   | read data memory at ALUOut, wait for ready
// MEMWB   | 4   | write MDR into rt
// MEMWR   | 5   | write B to memory at ALUOut, wait for ready
// EXEC    | 6   | R-type ALU operation on A, B
// ALUWB   | 7   | write ALUOut into rd
// BRANCH  | 8   | compare A, B; load PC from ALUOut when equal
// ADDIEX  | 9   | A + SignImm
// ADDIWB  | 10  | write ALUOut into rt
// JUMP    | 11  | load PC with jump target
module mips_multicycle_control (
    input  logic                              clk,
    input  logic                              rst,
    mips_multicycle_control_if.master         mem,
    input  logic [5:0]                        Opcode,
    input  logic                              Zero,
    output logic                              I_or_D,
    output logic                              IR_Write,
    output logic                              PC_En,
    output logic                              Reg_Dst,
    output logic                              Mem_to_Reg,
    output logic                              Reg_Write,
    output logic                              ALU_Src_A,
    output logic [1:0]                        ALU_Src_B,
    output logic [1:0]                        ALU_Op,
    output logic [1:0]                        PC_Src,
    output logic [3:0]                        State
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       branch;
        logic       pc_write;
    } ctrl_t;

    // FETCH's IR/PC write is qualified by Mem_Ready outside this table.
    function automatic ctrl_t ctrl_of(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.mem_req = 1'b1; c.alu_src_b = 2'b01; end
            S_DECODE: begin c.alu_src_b = 2'b11; end
            S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEMRD:  begin c.mem_req = 1'b1; c.i_or_d = 1'b1; end
            S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEMWR:  begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_ADDIWB: begin c.reg_write = 1'b1; end
            S_JUMP:   begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic state_t next_of(state_t s, logic [5:0] op, logic rdy);
        state_t n;
        n = S_FETCH;
        case (s)
            S_FETCH:  n = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: n = S_MEMADR;
                    OP_RTYPE:     n = S_EXEC;
                    OP_BEQ:       n = S_BRANCH;
                    OP_ADDI:      n = S_ADDIEX;
                    OP_J:         n = S_JUMP;
                    default:      n = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW)      n = S_MEMRD;
                else if (op == OP_SW) n = S_MEMWR;
                else                  n = S_FETCH;
            end
            S_MEMRD:  n = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:  n = rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   n = S_ALUWB;
            S_BRANCH: n = S_FETCH;
            S_ADDIEX: n = S_ADDIWB;
            default:  n = S_FETCH;
        endcase
        return n;
    endfunction

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   fetch_grant;

    always_comb state_nxt = next_of(state, Opcode, mem.Mem_Ready);

    // Outputs are registered alongside the state so they never glitch on decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            ctrl  <= ctrl_of(S_FETCH);
        end else begin
            state <= state_nxt;
            ctrl  <= ctrl_of(state_nxt);
        end
    end

    // Reset gates every enable so a held reset never issues a fetch or a write.
    assign fetch_grant   = (state == S_FETCH) & mem.Mem_Ready & ~rst;
    assign IR_Write      = fetch_grant;
    assign PC_En         = ~rst & (fetch_grant | ctrl.pc_write | (ctrl.branch & Zero));
    assign mem.Mem_Req   = ctrl.mem_req & ~rst;
    assign mem.Mem_Write = ctrl.mem_write & ~rst;
    assign Reg_Write     = ctrl.reg_write & ~rst;
    assign I_or_D        = ctrl.i_or_d;
    assign Reg_Dst       = ctrl.reg_dst;
    assign Mem_to_Reg    = ctrl.mem_to_reg;
    assign ALU_Src_A     = ctrl.alu_src_a;
    assign ALU_Src_B     = ctrl.alu_src_b;
    assign ALU_Op        = ctrl.alu_op;
    assign PC_Src        = ctrl.pc_src;
    assign State         = state;

endmodule
